// File: rtl/act_pkg.sv
// Shared types and FP16 helpers for the activation unit.
package act_pkg;

    // Per-beat activation mode, encoded as carried on the 2-bit mode field.
    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLAMP  = 2'd3
    } act_mode_e;

    localparam int          FP16_W       = 16;
    localparam int          FP16_EXP_W   = 5;
    localparam int          FP16_MAN_W   = 10;
    localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
        return (x[FP16_W-2 -: FP16_EXP_W] == FP16_EXP_MAX) &&
               (x[FP16_MAN_W-1:0] != '0);
    endfunction

    // Sign bit, kept as a helper so lane logic reads in FP16 terms.
    function automatic logic fp16_is_neg(input logic [FP16_W-1:0] x);
        return x[FP16_W-1];
    endfunction

endpackage

// File: rtl/act_if.sv
// Beat handshake bundle between the drain side, the activation unit and the result buffer.
interface act_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*16-1:0]   in_data;
    logic [1:0]            in_mode;
    logic [15:0]           cap;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*16-1:0]   out_data;

    // Producer/consumer side: drives input beats and the downstream ready.
    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output cap,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Activation unit side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  cap,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/act_lane.sv
// Combinational single-lane FP16 activation with rectification flag.
module act_lane
    import act_pkg::*;
#(
    parameter int LEAK_SHIFT = 3
) (
    input  logic [15:0] x,
    input  act_mode_e   mode,
    input  logic [15:0] cap,
    output logic [15:0] z,
    output logic        rectified
);

    localparam logic [4:0] LEAK_EXP = 5'(LEAK_SHIFT);

    logic       w_neg;
    logic       w_nan;
    logic [4:0] w_exp;
    logic [4:0] w_leak_exp;

    assign w_neg      = fp16_is_neg(x);
    assign w_nan      = fp16_is_nan(x);
    assign w_exp      = x[14:10];
    // Only used when w_exp > LEAK_EXP, so it never underflows.
    assign w_leak_exp = w_exp - LEAK_EXP;

    // Select the lane result; rectified marks a zero produced from a negative input.
    always_comb begin
        z         = x;
        rectified = 1'b0;
        case (mode)
            ACT_BYPASS: begin
                z = x;
            end
            ACT_RELU: begin
                if (w_nan) begin
                    z = FP16_QNAN;
                end else if (w_neg) begin
                    z         = FP16_ZERO;
                    rectified = 1'b1;
                end
            end
            ACT_LEAKY: begin
                if (w_nan) begin
                    z = FP16_QNAN;
                end else if (w_neg) begin
                    if (w_exp == FP16_EXP_MAX) begin
                        // -inf scaled by a power of two stays -inf.
                        z = x;
                    end else if (w_exp > LEAK_EXP) begin
                        z = {1'b1, w_leak_exp, x[9:0]};
                    end else begin
                        // Would land in the subnormal range: flush to zero.
                        z         = FP16_ZERO;
                        rectified = 1'b1;
                    end
                end
            end
            ACT_CLAMP: begin
                if (w_nan) begin
                    z = FP16_QNAN;
                end else if (w_neg) begin
                    z         = FP16_ZERO;
                    rectified = 1'b1;
                end else if (x[14:0] > cap[14:0]) begin
                    // Magnitude order matches unsigned order for non-negative FP16.
                    z = cap;
                end
            end
            default: begin
                z = x;
            end
        endcase
    end

endmodule

// File: rtl/act_unit.sv
// Pipelined multi-lane FP16 activation unit with a saturating rectified-lane counter.
module act_unit
    import act_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    act_if.slave             bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] rect_cnt
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    act_mode_e             w_mode;
    logic [LANES*16-1:0]   w_lane_z;
    logic [LANES-1:0]      w_lane_rect;
    logic [PC_W-1:0]       w_pop;
    logic                  w_s1_load;
    logic                  w_s2_load;
    logic                  w_out_fire;
    logic [SUM_W-1:0]      w_cnt_sum;
    logic [CNT_W-1:0]      w_cnt_sat;

    logic                  r_v1;
    logic [LANES*16-1:0]   r_d1;
    logic [PC_W-1:0]       r_pop1;
    logic                  r_v2;
    logic [LANES*16-1:0]   r_d2;
    logic [PC_W-1:0]       r_pop2;
    logic [CNT_W-1:0]      r_cnt;

    assign w_mode = act_mode_e'(bus.in_mode);

    // One combinational lane per FP16 element, all sharing the beat's mode and cap.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            act_lane #(
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_lane (
                .x         (bus.in_data[16*gi +: 16]),
                .mode      (w_mode),
                .cap       (bus.cap),
                .z         (w_lane_z[16*gi +: 16]),
                .rectified (w_lane_rect[gi])
            );
        end
    endgenerate

    // Count rectified lanes of the incoming beat.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_pop = w_pop + PC_W'(w_lane_rect[k]);
        end
    end

    // Stage advance: S2 drains when empty or accepted, S1 follows S2.
    assign w_s2_load  = !r_v2 || bus.out_ready;
    assign w_s1_load  = !r_v1 || w_s2_load;
    assign w_out_fire = r_v2 && bus.out_ready;

    // Ready is forced low during reset so nothing is taken while state is clearing.
    assign bus.in_ready = rst_n && w_s1_load;

    // S1: capture activated lanes and popcount of an accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_d1   <= '0;
            r_pop1 <= '0;
        end else if (w_s1_load) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_d1   <= w_lane_z;
                r_pop1 <= w_pop;
            end
        end
    end

    // S2: output register, held stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_d2   <= '0;
            r_pop2 <= '0;
        end else if (w_s2_load) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d2   <= r_d1;
                r_pop2 <= r_pop1;
            end
        end
    end

    // Saturating add of the departing beat's popcount.
    assign w_cnt_sum = SUM_W'(r_cnt) + SUM_W'(r_pop2);
    assign w_cnt_sat = (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    // Rectified-lane counter; a clear overrides a coincident increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_fire) begin
            r_cnt <= w_cnt_sat;
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.out_data  = r_d2;
    assign rect_cnt      = r_cnt;

endmodule

// File: tb/tb_act_unit.sv
// Scoreboard bench for act_unit: driver pushes expected beats, monitor pops and compares.
module tb_act_unit;

    localparam int LANES      = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] rect_cnt;

    act_if #(.LANES(LANES)) bus ();

    act_unit #(
        .LANES      (LANES),
        .LEAK_SHIFT (LEAK_SHIFT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .rect_cnt (rect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*16-1:0] data;
        int                  rect;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   or_mode  = 0;   // 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled
    bit   rand_clr = 1'b0;
    int   cyc      = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    // Reference: value-level rules for one FP16 lane.
    function automatic void ref_lane(input logic [15:0] x, input int mode, input logic [15:0] cap,
                                     output logic [15:0] z, output int rect);
        int e    = int'(x[14:10]);
        int frac = int'(x[9:0]);
        bit neg  = x[15];
        z    = x;
        rect = 0;
        if (mode == 0) return;
        if (e == 31 && frac != 0) begin
            z = 16'h7E00;
            return;
        end
        if (!neg) begin
            if (mode == 3 && x[14:0] > cap[14:0]) z = cap;
            return;
        end
        if (mode == 2 && e == 31) return;
        if (mode == 2 && e > LEAK_SHIFT) begin
            z = {1'b1, 5'(e - LEAK_SHIFT), x[9:0]};
            return;
        end
        z    = 16'h0000;
        rect = 1;
    endfunction

    function automatic exp_t ref_beat(input logic [LANES*16-1:0] d, input int mode, input logic [15:0] cap);
        exp_t        r;
        logic [15:0] z;
        int          rc;
        r.data = '0;
        r.rect = 0;
        for (int k = 0; k < LANES; k++) begin
            ref_lane(d[16*k +: 16], mode, cap, z, rc);
            r.data[16*k +: 16] = z;
            r.rect += rc;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat, wait (bounded) for acceptance, record its expected response.
    task automatic send(input logic [LANES*16-1:0] d, input int mode, input logic [15:0] c);
        exp_t e;
        int   waited = 0;
        e = ref_beat(d, mode, c);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = 2'(mode);
        bus.cap      = c;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1 within 200 cycles");
        end else begin
            sb.push_back(e);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    // Downstream ready pattern and optional random counter clears.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            2:       bus.out_ready = ($urandom % 3) != 0;
            default: bus.out_ready = 1'b0;
        endcase
        if (rand_clr) cnt_clr = (($urandom % 16) == 0);
    end

    // Monitor: compares output beats against the scoreboard and tracks the counter.
    int          occ = 0;
    int          mcnt = 0;
    bit          armed = 1'b0;
    bit          rst_seen = 1'b0;
    bit          held = 1'b0;
    logic [63:0] held_data = '0;
    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (armed) check("rect_cnt", 64'(rect_cnt), 64'(mcnt));
        if (!rst_n) begin
            check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
            sb.delete();
            occ      = 0;
            mcnt     = 0;
            held     = 1'b0;
            rst_seen = 1'b1;
            armed    = 1'b1;
        end else begin
            if (rst_seen) begin
                check("out_valid_after_reset", 64'(bus.out_valid), 64'd0);
                check("out_data_after_reset", bus.out_data, 64'd0);
                rst_seen = 1'b0;
            end
            check("in_ready", 64'(bus.in_ready), (occ == 2 && !bus.out_ready) ? 64'd0 : 64'd1);
            if (held) begin
                check("held_valid", 64'(bus.out_valid), 64'd1);
                check("held_data", bus.out_data, held_data);
            end
            held      = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            n = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h required no beat", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.data);
                    n = e.rect;
                end
                occ--;
            end
            if (bus.in_valid && bus.in_ready) occ++;
            if (cnt_clr) mcnt = 0;
            else if (bus.out_valid && bus.out_ready) mcnt = (mcnt + n > CNT_MAX) ? CNT_MAX : mcnt + n;
        end
    end

    logic [15:0] specials [0:11] = '{16'h3C00, 16'hBC00, 16'h8000, 16'h0000, 16'h7C00, 16'hFC00,
                                     16'h7E01, 16'hFE00, 16'h8400, 16'h8001, 16'h4600, 16'hC000};

    function automatic logic [15:0] rand_lane();
        if ($urandom % 2 == 0) return specials[$urandom_range(0, 11)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [LANES*16-1:0] d;
        logic [15:0]         c;
        int                  waited;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'd0;
        bus.cap       = 16'h0000;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // ReLU basic beat and its rectified count.
        or_mode = 0;
        pulse_clr();
        send({16'h7C00, 16'h8000, 16'hBC00, 16'h3C00}, 1, 16'h0000);
        repeat (4) step();
        check("relu_rect_cnt", 64'(rect_cnt), 64'd2);

        // Leaky ReLU corner values.
        send({16'h7E01, 16'hFC00, 16'h8400, 16'hBC00}, 2, 16'h0000);
        send({16'hC400, 16'h83FF, 16'h8000, 16'h4000}, 2, 16'h0000);
        send({16'h9000, 16'h8C00, 16'hFBFF, 16'h0001}, 2, 16'h0000);

        // Clamp against 6.0, then NaN bypass.
        send({16'hC000, 16'h7C00, 16'h4500, 16'h4700}, 3, 16'h4600);
        send({16'h7E01, 16'h4600, 16'h8000, 16'h0000}, 3, 16'h4600);
        send({16'h1234, 16'h8000, 16'hFC00, 16'h7E01}, 0, 16'h0000);
        repeat (4) step();

        // Backpressure stream with ready pattern 1,0,0.
        or_mode = 1;
        for (int i = 0; i < 8; i++) begin
            d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
            send(d, i % 4, 16'h4600);
        end
        or_mode = 0;
        repeat (6) step();

        // Counter saturation, then clear coincident with an accepted beat.
        pulse_clr();
        for (int i = 0; i < 5; i++) send({16'hC000, 16'hFC00, 16'h8000, 16'hBC00}, 1, 16'h0000);
        repeat (4) step();
        check("cnt_saturated", 64'(rect_cnt), 64'(CNT_MAX));
        send({16'hC000, 16'hFC00, 16'h8000, 16'hBC00}, 1, 16'h0000);
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", 64'(rect_cnt), 64'd0);
        repeat (3) step();

        // Reset with both stages full.
        or_mode = 3;
        step();
        step();
        send({16'hBC00, 16'hBC00, 16'h3C00, 16'h3C00}, 1, 16'h0000);
        send({16'h4000, 16'hC000, 16'h4000, 16'hC000}, 1, 16'h0000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rect_cnt_after_reset", 64'(rect_cnt), 64'd0);
        or_mode = 0;
        repeat (6) step();

        // Randomized traffic with random backpressure and clears.
        or_mode  = 2;
        rand_clr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
            c = {1'b0, 5'($urandom_range(0, 30)), 10'($urandom)};
            send(d, int'($urandom_range(0, 3)), c);
        end
        rand_clr = 1'b0;
        step();
        cnt_clr = 1'b0;
        or_mode = 0;

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            waited++;
            step();
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/act_unit.md
Name: act_unit

Overview:
Parametrised, pipelined FP16 activation unit for the systolic array output path. It processes LANES FP16 values per beat and supports four per-beat modes: bypass, ReLU, leaky ReLU (power-of-two slope) and clamped ReLU. It uses a valid/ready handshake with full-throughput backpressure, and keeps a saturating statistics counter of rectified elements. It sits between the PE-array drain/accumulator and the result buffer.

Parameters:
LANES, 4, number of FP16 lanes per beat (1..32)
LEAK_SHIFT, 3, leaky slope exponent; negative x maps to x * 2^-LEAK_SHIFT (1..14)
CNT_W, 32, width of rectified-element counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
in_data  in  LANES*16  FP16 lanes; lane k = bits [16k+15:16k]
in_mode  in  2  0 BYPASS, 1 RELU, 2 LEAKY, 3 CLAMP; sampled with beat
cap  in  16  CLAMP ceiling, FP16, must be non-negative finite; sampled with beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*16  activated lanes
cnt_clr  in  1  synchronous clear of rect_cnt
rect_cnt  out  CNT_W  saturating count of rectified lanes

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, rect_cnt=0, pipeline valids cleared. in_ready=0 while rst_n=0. An in-flight beat is dropped.
- Pipeline: two register stages, S1 (classify/compute) and S2 (output). Latency is 2 cycles from in_valid&in_ready to out_valid, with no bubbles.
- Stage advance: S2 loads when !v2 | out_ready. S1 loads when !v1 | S2 loads. in_ready = !v1 | !v2 | out_ready. Throughput is 1 beat/cycle while out_ready=1.
- Holding: while out_valid & !out_ready, out_data is stable and no beat is lost. Mode and cap travel with the beat.
- Per-lane function (s=sign, e=exp[14:10], m=mant):
  - NaN (e=31, m!=0): BYPASS passes it unchanged; every other mode outputs canonical 16'h7E00.
  - BYPASS: z=x.
  - RELU: s=1 (includes -0, -inf) gives 16'h0000; otherwise z=x.
  - LEAKY: s=0 gives z=x.
    - s=1, e=31 (-inf): z=x.
    - s=1, e>LEAK_SHIFT: z={1, e-LEAK_SHIFT, m}.
    - s=1, e<=LEAK_SHIFT (incl. subnormal, -0): flush to 16'h0000.
  - CLAMP: s=1 gives 16'h0000. s=0 with x[14:0] > cap[14:0] (unsigned compare, +inf included) gives z=cap. Otherwise z=x.
- Rectified lane: output 16'h0000 produced from an input with s=1 in RELU, LEAKY or CLAMP mode (NaN excluded).
- Counter: on an out_valid&out_ready beat, rect_cnt += number of rectified lanes in that beat. It saturates at 2^CNT_W-1 (no wrap).
  - Per-beat popcount is computed in S1 and carried to S2.
  - cnt_clr in the same cycle as an increment: clear wins and that beat's count is discarded.

Decomposition:
- Package act_pkg:
  - mode enum act_mode_e (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP)
  - FP16 constants FP16_W=16, FP16_EXP_W=5, FP16_MAN_W=10, FP16_EXP_MAX=31, FP16_QNAN=16'h7E00, FP16_ZERO
  - function fp16_is_nan
- Sub-module act_lane: combinational single-lane function. Ports x, mode, cap, z, rectified. Parameter LEAK_SHIFT. Generate-instantiated LANES times ahead of S1.

Test Plan:
- LANES=4, RELU, in_data lanes {3C00, BC00, 8000, 7C00}, out_ready=1 -> 2 cycles later {3C00, 0000, 0000, 7C00}; rect_cnt=2.
- LEAKY, LEAK_SHIFT=3: BC00 (-1.0) -> B000 (-0.125); 8400 (e=1) -> 0000; FC00 -> FC00; 7E01 -> 7E00; 4000 -> 4000.
- CLAMP, cap=4600 (6.0): 4700 -> 4600; 4500 -> 4500; 7C00 -> 4600; C000 -> 0000. BYPASS 7E01 -> 7E01.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> all 8 beats exit in order, unmodified while held, in_ready drops only when both stages are full and out_ready=0.
- Counter: CNT_W=4, 5 beats each with 4 negative lanes in RELU -> rect_cnt saturates at 15. cnt_clr coincident with an accepted beat -> rect_cnt=0.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages valid -> out_valid=0 and out_data=0 next cycle, rect_cnt=0, no stale beat emerges after release.
